// File: rtl/divide_if.sv
// Request/response bundle between the issuing stage and the iterative divider.
// The issuing stage drives operands and the request strobe; the divider returns busy, done pulse and results.
interface divide_if #(
  parameter int XLEN = 64
);
  logic            div_valid;
  logic [XLEN-1:0] x;
  logic [XLEN-1:0] y;
  logic            div_signed;
  logic            div_word;
  logic            div_busy;
  logic            div_data_ok;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output div_valid, x, y, div_signed, div_word,
    input  div_busy, div_data_ok, quotient, remainder
  );

  modport slave (
    input  div_valid, x, y, div_signed, div_word,
    output div_busy, div_data_ok, quotient, remainder
  );
endinterface

// File: rtl/divide.sv
// Iterative restoring divider for RV64 DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at accept.
module divide #(
  parameter int XLEN = 64
) (
  input  logic     clk,
  input  logic     rst,
  divide_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXECUTE, DONE} state_t;

  state_t state, state_nx;

  logic [6:0]      cnt;
  logic            busy_r;
  logic            ok_r;
  logic [XLEN-1:0] quotient_r;
  logic [XLEN-1:0] remainder_r;

  // Datapath state: no reset, always loaded at accept before use.
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dsr;
  logic [XLEN-1:0] rem_p;
  logic [XLEN-1:0] quo;
  logic            sign_q;
  logic            sign_r;
  logic            word_q;

  logic accept, iter_en, finish;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Operand preparation from the live request inputs
  logic [XLEN-1:0] x_eff, y_eff, x_mag, y_mag;
  logic            sx, sy, sp_div0, sp_ovf, special;
  logic [XLEN-1:0] sp_q, sp_r;

  always_comb begin
    x_eff = bus.x;
    y_eff = bus.y;
    if (bus.div_word) begin
      x_eff = bus.div_signed ? sext32(bus.x) : {{(XLEN-32){1'b0}}, bus.x[31:0]};
      y_eff = bus.div_signed ? sext32(bus.y) : {{(XLEN-32){1'b0}}, bus.y[31:0]};
    end
    sx    = bus.div_signed & x_eff[XLEN-1];
    sy    = bus.div_signed & y_eff[XLEN-1];
    x_mag = apply_sign(x_eff, sx);
    y_mag = apply_sign(y_eff, sy);

    sp_div0 = (y_eff == '0);
    if (bus.div_word)
      sp_ovf = bus.div_signed && (bus.x[31:0] == 32'h8000_0000) && (bus.y[31:0] == 32'hFFFF_FFFF);
    else
      sp_ovf = bus.div_signed && (bus.x == {1'b1, {(XLEN-1){1'b0}}}) && (bus.y == '1);
    special = sp_div0 | sp_ovf;

    // Division by zero returns the dividend as remainder, W-ops sign-extended even when unsigned.
    if (sp_div0) begin
      sp_q = '1;
      sp_r = bus.div_word ? sext32(bus.x) : bus.x;
    end else begin
      sp_q = bus.div_word ? sext32(bus.x) : bus.x;
      sp_r = '0;
    end
  end

  // One restoring step; a set bit 64 of the shifted remainder always exceeds the divisor.
  logic [XLEN:0]   r_sh;
  logic [XLEN-1:0] trial;
  logic            q_bit;

  always_comb begin
    r_sh  = {rem_p, dvd[XLEN-1]};
    trial = r_sh[XLEN-1:0] - dsr;
    q_bit = r_sh[XLEN] | (r_sh[XLEN-1:0] >= dsr);
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.div_valid) state_nx = special ? DONE : EXECUTE;
      EXECUTE: if (cnt == 7'd1)   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: control strobes
  always_comb begin
    accept  = 1'b0;
    iter_en = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE:    accept  = bus.div_valid;
      EXECUTE: iter_en = 1'b1;
      DONE:    finish  = 1'b1;
      default: ;
    endcase
  end

  // Control and architecturally visible result registers
  logic [XLEN-1:0] q_fin, r_fin;

  always_comb begin
    q_fin = apply_sign(quo, sign_q);
    r_fin = apply_sign(rem_p, sign_r);
    if (word_q) begin
      q_fin = sext32(q_fin);
      r_fin = sext32(r_fin);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      busy_r      <= 1'b0;
      ok_r        <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      ok_r <= finish;
      if (accept)
        busy_r <= 1'b1;
      else if (finish)
        busy_r <= 1'b0;
      if (accept)
        cnt <= bus.div_word ? 7'd32 : 7'd64;
      else if (iter_en)
        cnt <= cnt - 7'd1;
      if (finish) begin
        quotient_r  <= q_fin;
        remainder_r <= r_fin;
      end
    end
  end

  // Datapath: operand latch at accept, then shift-subtract per iteration
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd    <= bus.div_word ? {x_mag[31:0], 32'b0} : x_mag;
      dsr    <= y_mag;
      word_q <= bus.div_word;
      if (special) begin
        quo    <= sp_q;
        rem_p  <= sp_r;
        sign_q <= 1'b0;
        sign_r <= 1'b0;
      end else begin
        quo    <= '0;
        rem_p  <= '0;
        sign_q <= sx ^ sy;
        sign_r <= sx;
      end
    end else if (iter_en) begin
      dvd   <= {dvd[XLEN-2:0], 1'b0};
      rem_p <= q_bit ? trial : r_sh[XLEN-1:0];
      quo   <= {quo[XLEN-2:0], q_bit};
    end
  end

  assign bus.div_busy    = busy_r;
  assign bus.div_data_ok = ok_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;

endmodule

// File: doc/divide.md
Name: divide

Overview:
- Iterative shift-subtract (restoring) divider in the EXU, sitting alongside the shift-add multiplier.
- Implements RV64 DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW semantics.
- Produces quotient and remainder together; the issuing stage selects the one it needs.
- Multi-cycle, single outstanding request, valid/ok pulse handshake.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- div_valid  in  1  request strobe; sampled only in IDLE.
- x  in  64  dividend.
- y  in  64  divisor.
- div_signed  in  1  1 = signed op (DIV/REM), 0 = unsigned.
- div_word  in  1  1 = 32-bit W-op on x[31:0]/y[31:0].
- div_busy  out  1  high from the cycle after accept until div_data_ok; requests are ignored while high.
- div_data_ok  out  1  one-cycle completion pulse.
- quotient  out  64  result quotient.
- remainder  out  64  result remainder.

Behaviour:
- Reset: state = IDLE; div_busy = 0; div_data_ok = 0; quotient = 0; remainder = 0; counter = 0. A reset asserted mid-operation aborts the operation silently and produces no div_data_ok.
- States: IDLE, EXECUTE, DONE.
- Accept: rising edge T with state == IDLE and div_valid == 1. All operands and flags are latched at T; later input changes have no effect.
- Operand prep at accept:
  - Word op: low 32 bits only, sign-extended if div_signed, zero-extended otherwise. Iteration count N = 32.
  - Double op: N = 64.
  - Signed op: record sign_q = sx ^ sy and sign_r = sx, then divide the magnitudes.
- Special cases, decided at accept; these skip EXECUTE and go IDLE -> DONE:
  - Divide by zero (effective divisor 0): quotient = all ones (0xFFFF_FFFF_FFFF_FFFF); remainder = the effective dividend, sign-extended to 64 for word ops.
  - Signed overflow:
    - Double: x = 0x8000_0000_0000_0000, y = -1 gives quotient = x, remainder = 0.
    - Word: x[31:0] = 0x8000_0000, y[31:0] = 0xFFFF_FFFF gives quotient = 0xFFFF_FFFF_8000_0000, remainder = 0.
- EXECUTE, one iteration per cycle, N cycles:
  - Partial remainder R (N+1 bits) shifts left, taking in the next dividend MSB; trial = R - divisor.
  - If trial is non-negative, R = trial and the quotient bit is 1; otherwise R is kept and the quotient bit is 0.
  - Counter is loaded with N at accept and decrements each iteration. When it reaches 0, go to DONE.
- DONE, one cycle:
  - Apply signs: negate the quotient if sign_q, negate the remainder if sign_r (signed ops only).
  - Word results are sign-extended from bit 31, for unsigned W-ops as well.
  - Register quotient/remainder, pulse div_data_ok = 1, drop div_busy, return to IDLE.
- Latency, measured as the div_data_ok pulse cycle relative to accept edge T:
  - Normal double op: edge T+65.
  - Normal word op: edge T+33.
  - Special case: edge T+1.
- Outputs: quotient/remainder hold their value until the next completion; they are not cleared in IDLE. div_data_ok is high for exactly one cycle per accepted request.
- Back-to-back: a new request may be accepted in the cycle after div_data_ok (state is IDLE). div_valid held high continuously starts a new operation every completion.
- div_valid during EXECUTE or DONE is ignored; there is no queuing.

Test Plan:
- Unsigned double: x = 100, y = 7, signed = 0, word = 0 -> at T+65 div_data_ok = 1, quotient = 14, remainder = 2; div_busy high T+1..T+64.
- Signed sign rules: x = -7 (0xFFFF_FFFF_FFFF_FFF9), y = 2, signed = 1 -> quotient = -3 (0xFFFF_FFFF_FFFF_FFFD), remainder = -1. Then x = 7, y = -2 -> quotient = -3, remainder = 1.
- Divide by zero: x = 0x1234, y = 0, signed = 1 -> at T+1 quotient = 0xFFFF_FFFF_FFFF_FFFF, remainder = 0x1234. Repeat with word = 1 and x = 0xDEAD_BEEF_8000_0001 -> remainder = 0xFFFF_FFFF_8000_0001.
- Overflow:
  - x = 0x8000_0000_0000_0000, y = -1, signed = 1 -> quotient = x, remainder = 0, at T+1.
  - Word with x[31:0] = 0x8000_0000, y = 0xFFFF_FFFF -> quotient = 0xFFFF_FFFF_8000_0000.
- Unsigned word: x = 0xFFFF_FFFF_FFFF_FFFE, y = 1, signed = 0, word = 1 -> at T+33 quotient = 0xFFFF_FFFF_FFFF_FFFE (sign-extended 0xFFFF_FFFE), remainder = 0.
- Robustness:
  - Toggle div_valid and change x/y during EXECUTE -> result unchanged, single div_data_ok pulse.
  - Assert rst at T+20 -> all outputs 0 immediately, no div_data_ok.
  - A new request after reset completes normally.
